// File: rtl/call_controller.sv
// Per-node call controller: UI commands and rx packets drive the call FSM; all outputs registered, 1-cycle latency.
// Single-entry tx register holds until tx_ready; commands needing tx while it is occupied are refused with cmd_err.
module call_controller #(
   parameter logic [7:0]  MY_ADDR      = 8'h01,
   parameter logic [15:0] RING_TIMEOUT = 16'd50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic [2:0] command,
   input  logic [7:0] address,
   output logic       cmd_ack,
   output logic       cmd_err,
   output logic       init,
   output logic       incoming_call,
   output logic [7:0] inc_address,
   output logic       call_active,
   output logic [7:0] peer_address,
   output logic       tx_valid,
   output logic [2:0] tx_type,
   output logic [7:0] tx_addr,
   input  logic       tx_ready,
   input  logic       rx_valid,
   input  logic [2:0] rx_type,
   input  logic [7:0] rx_addr
);

   typedef enum logic [2:0] {UNINIT, INIT_WAIT, IDLE, DIALING, RINGING, CONNECTED} state_t;

   localparam logic [2:0] PKT_INIT = 3'd0, PKT_REQ = 3'd1, PKT_ACC = 3'd2, PKT_REJ = 3'd3, PKT_END = 3'd4;
   localparam logic [2:0] CMD_INIT = 3'd0, CMD_CALL = 3'd1, CMD_ACCEPT = 3'd2, CMD_REJECT = 3'd3, CMD_END = 3'd4;

   state_t      state, state_nxt;
   logic [15:0] timer, timer_nxt;
   logic        tx_valid_nxt, cmd_ack_nxt, cmd_err_nxt, init_nxt, incoming_nxt, active_nxt;
   logic [2:0]  tx_type_nxt;
   logic [7:0]  tx_addr_nxt, inc_addr_nxt, peer_nxt;
   logic        tx_busy, rx_moved, timeout, rx_from_peer, in_call;

   assign in_call      = (state == DIALING) || (state == RINGING) || (state == CONNECTED);
   assign timeout      = ((state == DIALING) || (state == RINGING)) && (timer == RING_TIMEOUT - 16'd1);
   assign rx_from_peer = (rx_addr == peer_address);

   always_comb begin
      state_nxt    = state;
      timer_nxt    = ((state == DIALING) || (state == RINGING)) ? timer + 16'd1 : 16'd0;
      tx_valid_nxt = tx_valid && !tx_ready;
      tx_type_nxt  = tx_type;
      tx_addr_nxt  = tx_addr;
      cmd_ack_nxt  = 1'b0;
      cmd_err_nxt  = 1'b0;
      init_nxt     = init;
      incoming_nxt = incoming_call;
      inc_addr_nxt = inc_address;
      peer_nxt     = peer_address;
      tx_busy      = tx_valid;
      rx_moved     = 1'b0;

      if (rx_valid) begin
         case (state)
            UNINIT, INIT_WAIT: if (rx_type == PKT_INIT) begin
               init_nxt  = 1'b1;
               state_nxt = IDLE;
               rx_moved  = 1'b1;
            end
            IDLE: if (rx_type == PKT_REQ) begin
               state_nxt    = RINGING;
               incoming_nxt = 1'b1;
               inc_addr_nxt = rx_addr;
               peer_nxt     = rx_addr;
               timer_nxt    = 16'd0;
               rx_moved     = 1'b1;
            end
            DIALING: if (rx_from_peer && rx_type == PKT_ACC) begin
               state_nxt = CONNECTED;
               rx_moved  = 1'b1;
            end else if (rx_from_peer && (rx_type == PKT_REJ || rx_type == PKT_END)) begin
               state_nxt = IDLE;
               rx_moved  = 1'b1;
            end
            RINGING: if (rx_from_peer && rx_type == PKT_END) begin
               state_nxt    = IDLE;
               incoming_nxt = 1'b0;
               rx_moved     = 1'b1;
            end
            CONNECTED: if (rx_from_peer && rx_type == PKT_END) begin
               state_nxt = IDLE;
               rx_moved  = 1'b1;
            end
            default: ;
         endcase
         // Busy rejection to a third party: best effort, dropped when tx is occupied.
         if (!rx_moved && in_call && rx_type == PKT_REQ && !rx_from_peer && !tx_busy) begin
            tx_valid_nxt = 1'b1;
            tx_type_nxt  = PKT_REJ;
            tx_addr_nxt  = rx_addr;
            tx_busy      = 1'b1;
         end
      end

      if (timeout && !rx_moved) begin
         state_nxt    = IDLE;
         incoming_nxt = 1'b0;
         timer_nxt    = 16'd0;
         if (!tx_busy) begin
            tx_valid_nxt = 1'b1;
            tx_type_nxt  = (state == DIALING) ? PKT_END : PKT_REJ;
            tx_addr_nxt  = peer_address;
            tx_busy      = 1'b1;
         end
      end

      if (state == INIT_WAIT && !rx_moved && tx_valid && tx_ready && tx_type == PKT_INIT) begin
         init_nxt  = 1'b1;
         state_nxt = IDLE;
      end

      if (cmd_valid) begin
         cmd_err_nxt = 1'b1;
         if (!rx_moved && !timeout && !tx_busy) begin
            case (state)
               UNINIT: if (command == CMD_INIT) begin
                  tx_type_nxt = PKT_INIT;
                  tx_addr_nxt = 8'hFF;
                  state_nxt   = INIT_WAIT;
                  cmd_ack_nxt = 1'b1;
               end
               IDLE: if (command == CMD_CALL && address != MY_ADDR && address != 8'hFF) begin
                  tx_type_nxt = PKT_REQ;
                  tx_addr_nxt = address;
                  peer_nxt    = address;
                  state_nxt   = DIALING;
                  timer_nxt   = 16'd0;
                  cmd_ack_nxt = 1'b1;
               end
               DIALING, CONNECTED: if (command == CMD_END) begin
                  tx_type_nxt = PKT_END;
                  tx_addr_nxt = peer_address;
                  state_nxt   = IDLE;
                  cmd_ack_nxt = 1'b1;
               end
               RINGING: if (command == CMD_ACCEPT || command == CMD_REJECT) begin
                  tx_type_nxt  = (command == CMD_ACCEPT) ? PKT_ACC : PKT_REJ;
                  tx_addr_nxt  = peer_address;
                  state_nxt    = (command == CMD_ACCEPT) ? CONNECTED : IDLE;
                  incoming_nxt = 1'b0;
                  cmd_ack_nxt  = 1'b1;
               end
               default: ;
            endcase
            if (cmd_ack_nxt) begin
               tx_valid_nxt = 1'b1;
               cmd_err_nxt  = 1'b0;
            end
         end
      end

      active_nxt = (state_nxt == CONNECTED);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= UNINIT;
         timer         <= 16'd0;
         tx_valid      <= 1'b0;
         tx_type       <= 3'd0;
         tx_addr       <= 8'd0;
         cmd_ack       <= 1'b0;
         cmd_err       <= 1'b0;
         init          <= 1'b0;
         incoming_call <= 1'b0;
         inc_address   <= 8'd0;
         peer_address  <= 8'd0;
         call_active   <= 1'b0;
      end else begin
         state         <= state_nxt;
         timer         <= timer_nxt;
         tx_valid      <= tx_valid_nxt;
         tx_type       <= tx_type_nxt;
         tx_addr       <= tx_addr_nxt;
         cmd_ack       <= cmd_ack_nxt;
         cmd_err       <= cmd_err_nxt;
         init          <= init_nxt;
         incoming_call <= incoming_nxt;
         inc_address   <= inc_addr_nxt;
         peer_address  <= peer_nxt;
         call_active   <= active_nxt;
      end
   end

endmodule

// File: tb/tb_call_controller.sv
// Directed bench for call_controller with a short ring timeout (16 cycles).
module tb_call_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [2:0] command = 3'd0;
   logic [7:0] address = 8'd0;
   logic       cmd_ack, cmd_err, init, incoming_call, call_active, tx_valid;
   logic [7:0] inc_address, peer_address, tx_addr;
   logic [2:0] tx_type;
   logic       tx_ready = 1'b1;
   logic       rx_valid = 1'b0;
   logic [2:0] rx_type = 3'd0;
   logic [7:0] rx_addr = 8'd0;

   int checks = 0;
   int failures = 0;

   call_controller #(.MY_ADDR(8'h01), .RING_TIMEOUT(16'd16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .command(command), .address(address),
      .cmd_ack(cmd_ack), .cmd_err(cmd_err),
      .init(init), .incoming_call(incoming_call), .inc_address(inc_address),
      .call_active(call_active), .peer_address(peer_address),
      .tx_valid(tx_valid), .tx_type(tx_type), .tx_addr(tx_addr), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_type(rx_type), .rx_addr(rx_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cmd(input logic [2:0] c, input logic [7:0] a);
      cmd_valid = 1'b1; command = c; address = a;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic do_rx(input logic [2:0] t, input logic [7:0] a);
      rx_valid = 1'b1; rx_type = t; rx_addr = a;
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      // reset state
      tick(); tick();
      check("reset_flags", {init, incoming_call, call_active, tx_valid, cmd_ack, cmd_err}, 6'b0);
      check("reset_addrs", {inc_address, peer_address, tx_addr}, 24'h0);
      reset = 1'b1;
      tick();

      // initialisation via own INIT broadcast
      do_cmd(3'd0, 8'h00);
      check("init_ack_tx", {cmd_ack, cmd_err, tx_valid, tx_type, tx_addr}, {1'b1, 1'b0, 1'b1, 3'd0, 8'hFF});
      check("init_not_yet", init, 1'b0);
      tick();
      check("init_done", {init, tx_valid, cmd_ack}, 3'b100);

      // outgoing call, accepted, then ended locally
      do_cmd(3'd1, 8'h07);
      check("dial_tx", {cmd_ack, tx_valid, tx_type, tx_addr, peer_address}, {1'b1, 1'b1, 3'd1, 8'h07, 8'h07});
      tick();
      do_rx(3'd2, 8'h07);
      check("dial_connect", {call_active, tx_valid}, 2'b10);
      do_cmd(3'd4, 8'h00);
      check("end_tx", {cmd_ack, tx_valid, tx_type, tx_addr, call_active}, {1'b1, 1'b1, 3'd4, 8'h07, 1'b0});
      tick();

      // illegal / refused commands in IDLE
      do_cmd(3'd1, 8'h01);
      check("call_self", {cmd_ack, cmd_err, tx_valid}, 3'b010);
      do_cmd(3'd1, 8'hFF);
      check("call_bcast", {cmd_ack, cmd_err}, 2'b01);
      do_cmd(3'd6, 8'h00);
      check("cmd_illegal", {cmd_ack, cmd_err}, 2'b01);

      // incoming call left ringing until timeout
      do_rx(3'd1, 8'h22);
      check("ring_start", {incoming_call, inc_address, peer_address}, {1'b1, 8'h22, 8'h22});
      repeat (15) tick();
      check("ring_pre_timeout", {incoming_call, tx_valid}, 2'b10);
      tick();
      check("ring_timeout", {incoming_call, tx_valid, tx_type, tx_addr}, {1'b0, 1'b1, 3'd3, 8'h22});
      tick();
      check("ring_tx_clear", tx_valid, 1'b0);

      // busy rejection while connected
      do_cmd(3'd1, 8'h07);
      tick();
      do_rx(3'd2, 8'h07);
      check("reconnect", call_active, 1'b1);
      do_rx(3'd1, 8'h09);
      check("busy_rej", {call_active, tx_valid, tx_type, tx_addr}, {1'b1, 1'b1, 3'd3, 8'h09});
      tick();
      do_cmd(3'd4, 8'h00);
      tick();
      check("back_idle", {call_active, tx_valid}, 2'b00);

      // stalled tx register and rx/cmd collision
      tx_ready = 1'b0;
      do_cmd(3'd1, 8'h07);
      check("stall_dial", {cmd_ack, tx_valid, tx_type}, {1'b1, 1'b1, 3'd1});
      do_cmd(3'd4, 8'h00);
      check("stall_end_err", {cmd_ack, cmd_err, tx_valid, tx_type, tx_addr}, {1'b0, 1'b1, 1'b1, 3'd1, 8'h07});
      do_rx(3'd2, 8'h08);
      check("acc_nonpeer", call_active, 1'b0);
      rx_valid = 1'b1; rx_type = 3'd2; rx_addr = 8'h07;
      cmd_valid = 1'b1; command = 3'd4;
      tick();
      rx_valid = 1'b0; cmd_valid = 1'b0;
      check("rx_beats_cmd", {call_active, cmd_ack, cmd_err}, 3'b101);
      tx_ready = 1'b1;
      tick();
      check("stall_release", tx_valid, 1'b0);
      do_cmd(3'd4, 8'h00);
      tick();

      // reset mid-call drops everything, including a stalled packet
      tx_ready = 1'b0;
      do_cmd(3'd1, 8'h07);
      check("pre_reset_dial", tx_valid, 1'b1);
      reset = 1'b0;
      tick();
      check("midreset_flags", {init, incoming_call, call_active, tx_valid, cmd_ack, cmd_err}, 6'b0);
      check("midreset_addrs", {inc_address, peer_address, tx_addr, 5'd0, tx_type}, 32'h0);
      reset = 1'b1;
      tx_ready = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
